pulse_period_meter: RTL and testbench

Synthesizable measurement block for an astable pulse train, such as the modelled 555 timer output: it samples the pulse, counts high and low phase lengths in `clk` cycles, and publishes each complete cycle as a result over a valid/ready handshake. It is the receiving end of the lab timer chain and feeds the duty-cycle display and checking logic.

---
 rtl/pulse_period_meter.sv | 145 ++++++++++++++
 tb/tb_pulse_period_meter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// rtl/pulse_period_meter.sv - high/low phase meter for a pulse train with valid/ready result
// Optional feature: define PULSE_METER_GLITCH_FILTER_EN for a 3-sample glitch filter on the input.
module pulse_period_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W:0]   period,
   output logic             meas_valid,
   input  logic             meas_ready,
   output logic             overrun,
   output logic             saturated
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic                   p_s;
   logic                   p_s_d;
   logic                   rise;
   logic                   fall;
   logic [CNT_W-1:0]       hcnt;
   logic [CNT_W-1:0]       lcnt;
   logic                   hcnt_sat;
   logic                   lcnt_sat;
   logic                   publish;
   logic                   accept;

   // bring the asynchronous pulse into the clk domain
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PULSE_METER_GLITCH_FILTER_EN
   logic [1:0] filt_hist;
   logic       filt_q;

   // keep two past samples and the last accepted level; a new level is taken
   // combinationally once three consecutive samples agree
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_hist <= '0;
         filt_q    <= 1'b0;
      end else begin
         filt_hist <= {filt_hist[0], sync_out};
         filt_q    <= p_s;
      end
   end

   assign p_s = (sync_out == filt_hist[0] && sync_out == filt_hist[1]) ? sync_out : filt_q;
`else
   assign p_s = sync_out;
`endif

   // one-flop history of the clean level for edge strobes
   always_ff @(posedge clk) begin
      if (rst) p_s_d <= 1'b0;
      else     p_s_d <= p_s;
   end

   assign rise     = p_s & ~p_s_d;
   assign fall     = ~p_s & p_s_d;
   assign hcnt_sat = (hcnt == CNT_MAX);
   assign lcnt_sat = (lcnt == CNT_MAX);
   assign publish  = enable && (state == MEAS_LOW) && rise;
   assign accept   = meas_valid && meas_ready;

   // phase-measurement FSM plus the registered result / handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hcnt       <= '0;
         lcnt       <= '0;
         high_cnt   <= '0;
         low_cnt    <= '0;
         period     <= '0;
         meas_valid <= 1'b0;
         overrun    <= 1'b0;
         saturated  <= 1'b0;
      end else begin
         if (!enable) begin
            // partial cycle is discarded; any held result stays put
            state <= IDLE;
            hcnt  <= '0;
            lcnt  <= '0;
         end else begin
            case (state)
               IDLE: state <= WAIT_RISE;
               WAIT_RISE: begin
                  if (rise) begin
                     hcnt  <= CNT_ONE;
                     state <= MEAS_HIGH;
                  end
               end
               MEAS_HIGH: begin
                  if (fall) begin
                     lcnt  <= CNT_ONE;
                     state <= MEAS_LOW;
                  end else if (p_s && !hcnt_sat) begin
                     hcnt <= hcnt + CNT_ONE;
                  end
               end
               MEAS_LOW: begin
                  if (rise) begin
                     hcnt  <= CNT_ONE;
                     state <= MEAS_HIGH;
                  end else if (!p_s && !lcnt_sat) begin
                     lcnt <= lcnt + CNT_ONE;
                  end
               end
               default: state <= IDLE;
            endcase
         end

         if (publish) begin
            if (!meas_valid || meas_ready) begin
               high_cnt   <= hcnt;
               low_cnt    <= lcnt;
               period     <= {1'b0, hcnt} + {1'b0, lcnt};
               meas_valid <= 1'b1;
               saturated  <= hcnt_sat | lcnt_sat;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pulse_period_meter.sv
// tb/tb_pulse_period_meter.sv - directed self-checking bench for pulse_period_meter
`timescale 1ns/1ps
module tb_pulse_period_meter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        enable;
   logic        pulse_in;
   logic        meas_ready;
   logic [15:0] high_cnt;
   logic [15:0] low_cnt;
   logic [16:0] period;
   logic        meas_valid;
   logic        overrun;
   logic        saturated;

   logic        s_enable;
   logic        s_pulse;
   logic        s_ready;
   logic [3:0]  s_high;
   logic [3:0]  s_low;
   logic [4:0]  s_period;
   logic        s_valid;
   logic        s_overrun;
   logic        s_sat;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          gen_h      = 1;
   int          gen_l      = 1;
   bit          gen_glitch = 1'b0;
   int          s_h = 20;
   int          s_l = 3;

   logic [15:0] hold_h;
   logic [15:0] hold_l;
   int          changes;
   int          seen;
   bit          prev_p;

`ifdef PULSE_METER_GLITCH_FILTER_EN
   localparam int GL_H = 10;
   localparam int GL_L = 10;
`else
   localparam int GL_H = 5;
   localparam int GL_L = 1;
`endif

   pulse_period_meter u_dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .pulse_in   (pulse_in),
      .high_cnt   (high_cnt),
      .low_cnt    (low_cnt),
      .period     (period),
      .meas_valid (meas_valid),
      .meas_ready (meas_ready),
      .overrun    (overrun),
      .saturated  (saturated)
   );

   pulse_period_meter #(.CNT_W(4)) u_sat (
      .clk        (clk),
      .rst        (rst),
      .enable     (s_enable),
      .pulse_in   (s_pulse),
      .high_cnt   (s_high),
      .low_cnt    (s_low),
      .period     (s_period),
      .meas_valid (s_valid),
      .meas_ready (s_ready),
      .overrun    (s_overrun),
      .saturated  (s_sat)
   );

   // main pulse train; shape is latched at the start of every period
   initial begin
      int  h, l;
      bit  g;
      pulse_in = 1'b0;
      @(negedge clk);
      forever begin
         h = gen_h;
         l = gen_l;
         g = gen_glitch;
         if (g) begin
            pulse_in = 1'b1; repeat (5) @(negedge clk);
            pulse_in = 1'b0; @(negedge clk);
            pulse_in = 1'b1; repeat (4) @(negedge clk);
         end else begin
            pulse_in = 1'b1; repeat (h) @(negedge clk);
         end
         pulse_in = 1'b0; repeat (l) @(negedge clk);
      end
   end

   // pulse train for the narrow-counter instance
   initial begin
      int h, l;
      s_pulse = 1'b0;
      @(negedge clk);
      forever begin
         h = s_h;
         l = s_l;
         s_pulse = 1'b1; repeat (h) @(negedge clk);
         s_pulse = 1'b0; repeat (l) @(negedge clk);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_res(input string tag);
      int n;
      n = 0;
      tick();
      while (!meas_valid && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {31'd0, meas_valid}, 1);
   endtask

   task automatic wait_sres(input string tag);
      int n;
      n = 0;
      tick();
      while (!s_valid && n < 400) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {31'd0, s_valid}, 1);
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b1;
      s_enable   = 1'b1;
      meas_ready = 1'b1;
      s_ready    = 1'b1;

      // reset with input toggling
      repeat (3) tick();
      chk("rst_high", {16'd0, high_cnt}, 0);
      chk("rst_low", {16'd0, low_cnt}, 0);
      chk("rst_period", {15'd0, period}, 0);
      chk("rst_valid", {31'd0, meas_valid}, 0);
      chk("rst_overrun", {31'd0, overrun}, 0);
      chk("rst_sat", {31'd0, saturated}, 0);
      chk("rst_s_valid", {31'd0, s_valid}, 0);

      // disabled: never a result
      enable   = 1'b0;
      s_enable = 1'b0;
      gen_h    = 3;
      gen_l    = 3;
      rst      = 1'b0;
      seen     = 0;
      repeat (60) begin
         tick();
         if (meas_valid) seen++;
      end
      chk("idle_no_valid", seen, 0);

      // saturation on the 4-bit instance
      s_enable = 1'b1;
      wait_sres("sat_d");
      wait_sres("sat");
      chk("sat_high", {28'd0, s_high}, 15);
      chk("sat_low", {28'd0, s_low}, 3);
      chk("sat_period", {27'd0, s_period}, 18);
      chk("sat_flag", {31'd0, s_sat}, 1);
      s_h = 5;
      s_l = 5;
      wait_sres("unsat_d");
      wait_sres("unsat");
      chk("unsat_high", {28'd0, s_high}, 5);
      chk("unsat_low", {28'd0, s_low}, 5);
      chk("unsat_period", {27'd0, s_period}, 10);
      chk("unsat_flag", {31'd0, s_sat}, 0);
      s_enable = 1'b0;

      // steady train 35/25
      gen_h  = 35;
      gen_l  = 25;
      enable = 1'b1;
      wait_res("steady_d0");
      wait_res("steady_d1");
      for (int i = 0; i < 3; i++) begin
         wait_res("steady");
         chk("steady_high", {16'd0, high_cnt}, 35);
         chk("steady_low", {16'd0, low_cnt}, 25);
         chk("steady_period", {15'd0, period}, 60);
      end
      chk("steady_sat", {31'd0, saturated}, 0);
      chk("steady_overrun", {31'd0, overrun}, 0);

      // back-pressure 4/4
      gen_h = 4;
      gen_l = 4;
      wait_res("bp_d");
      wait_res("bp_first");
      meas_ready = 1'b0;
      chk("bp_first_high", {16'd0, high_cnt}, 4);
      chk("bp_first_low", {16'd0, low_cnt}, 4);
      hold_h  = high_cnt;
      hold_l  = low_cnt;
      changes = 0;
      repeat (40) begin
         tick();
         if (high_cnt !== hold_h || low_cnt !== hold_l || meas_valid !== 1'b1) changes++;
      end
      chk("bp_stable", changes, 0);
      chk("bp_overrun", {31'd0, overrun}, 1);
      // accept for one cycle, placed just after an input rise so it lands between publishes
      prev_p = pulse_in;
      seen   = 0;
      tick();
      while (!(pulse_in && !prev_p) && seen < 50) begin
         prev_p = pulse_in;
         tick();
         seen++;
      end
      tick();
      meas_ready = 1'b1;
      tick();
      meas_ready = 1'b0;
      chk("bp_acc_valid", {31'd0, meas_valid}, 0);
      chk("bp_acc_overrun", {31'd0, overrun}, 0);
      meas_ready = 1'b1;
      wait_res("bp_next");
      chk("bp_next_high", {16'd0, high_cnt}, 4);
      chk("bp_next_low", {16'd0, low_cnt}, 4);
      chk("bp_next_overrun", {31'd0, overrun}, 0);

      // enable dropped during the low phase
      gen_h = 10;
      gen_l = 10;
      wait_res("en_d");
      wait_res("en_pre");
      repeat (15) tick();
      enable = 1'b0;
      repeat (3) tick();
      enable = 1'b1;
      wait_res("en_post");
      chk("en_post_high", {16'd0, high_cnt}, 10);
      chk("en_post_low", {16'd0, low_cnt}, 10);

      // reset while a result is held
      meas_ready = 1'b0;
      wait_res("rstv");
      rst = 1'b1;
      tick();
      chk("rstv_valid", {31'd0, meas_valid}, 0);
      chk("rstv_high", {16'd0, high_cnt}, 0);
      rst        = 1'b0;
      meas_ready = 1'b1;

      // one-cycle low glitch inside a 10-cycle high
      wait_res("gl_pre");
      gen_glitch = 1'b1;
      wait_res("gl_d");
      wait_res("gl");
      chk("gl_high", {16'd0, high_cnt}, GL_H);
      chk("gl_low", {16'd0, low_cnt}, GL_L);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
